// File: rtl/spin_motor_ramp_ctrl.sv
// Spin motor ramp controller: latches a target drum speed on start, ramps the
// commanded RPM up in fixed steps, holds for a programmed number of ticks,
// ramps back down to zero and pulses done.
// Latency: state/RPM change on the tick edge; pwm_out lags pwm_cnt/current_rpm by one cycle.
// Backpressure: none; start is a level sampled only in IDLE, abort forces an early ramp-down.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   target_rpm   requested spin speed (11 bits), latched on start in IDLE
//   start        level; begins a spin cycle when seen in IDLE with abort low
//   abort        level; in RAMP_UP/HOLD forces RAMP_DOWN on the next clock
//   current_rpm  commanded drum speed
//   pwm_out      registered motor-enable PWM, high while pwm_cnt < current_rpm
//   at_speed     high while in HOLD
//   busy         high in every state except IDLE
//   done         one-cycle pulse in the DONE state
//   state        IDLE=0, RAMP_UP=1, HOLD=2, RAMP_DOWN=3, DONE=4

module spin_motor_ramp_ctrl #(
    parameter int unsigned TICKS_PER_STEP = 1000,
    parameter logic [10:0] RAMP_STEP      = 11'd100,
    parameter int unsigned HOLD_TICKS     = 300,
    parameter logic [10:0] MAX_RPM        = 11'd1400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] target_rpm,
    input  logic        start,
    input  logic        abort,
    output logic [10:0] current_rpm,
    output logic        pwm_out,
    output logic        at_speed,
    output logic        busy,
    output logic        done,
    output logic [2:0]  state
);

    // Counter widths; the hold counter needs at least one bit even when a
    // single hold tick is programmed.
    localparam int PW = $clog2(TICKS_PER_STEP);
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_STEP - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RAMP_UP   = 3'd1,
        S_HOLD      = 3'd2,
        S_RAMP_DOWN = 3'd3,
        S_DONE      = 3'd4
    } state_e;

    state_e       state_q, state_d;
    logic [10:0]  tgt_q, tgt_d;
    logic [10:0]  cur_rpm_q, cur_rpm_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [10:0]  pwm_cnt_q, pwm_cnt_d;
    logic         pwm_out_q, pwm_out_d;

    // Shared conditions used by both the FSM and the datapath.
    logic        active;
    logic        tick;
    logic        start_ok;
    logic        abort_act;
    logic        up_last;
    logic        down_last;
    logic        hold_last;
    logic [10:0] tgt_clamped;

    assign active      = (state_q == S_RAMP_UP) || (state_q == S_HOLD) ||
                         (state_q == S_RAMP_DOWN);
    assign tick        = active && (presc_q == PRESC_LAST);
    assign start_ok    = start && !abort;
    // abort only matters while still accelerating or holding.
    assign abort_act   = abort && ((state_q == S_RAMP_UP) || (state_q == S_HOLD));
    assign tgt_clamped = (target_rpm > MAX_RPM) ? MAX_RPM : target_rpm;
    // cur_rpm_q never exceeds tgt_q in RAMP_UP, so the subtraction cannot wrap.
    assign up_last     = (tgt_q - cur_rpm_q) <= RAMP_STEP;
    assign down_last   = cur_rpm_q <= RAMP_STEP;
    assign hold_last   = (hold_q == HOLD_LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = (tgt_clamped == 11'd0) ? S_DONE : S_RAMP_UP;
                end
            end
            S_RAMP_UP: begin
                if (abort_act) begin
                    state_d = S_RAMP_DOWN;
                end else if (tick && up_last) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (abort_act) begin
                    state_d = S_RAMP_DOWN;
                end else if (tick && hold_last) begin
                    state_d = S_RAMP_DOWN;
                end
            end
            S_RAMP_DOWN: begin
                if (tick && down_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded from the registered state only
    // ------------------------------------------------------------------
    always_comb begin
        at_speed = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state_q)
            S_IDLE:  busy     = 1'b0;
            S_HOLD:  at_speed = 1'b1;
            S_DONE:  done     = 1'b1;
            default: begin
                at_speed = 1'b0;
            end
        endcase
    end

    assign state       = state_q;
    assign current_rpm = cur_rpm_q;
    assign pwm_out     = pwm_out_q;

    // ------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        tgt_d     = tgt_q;
        cur_rpm_d = cur_rpm_q;
        hold_d    = hold_q;

        // Prescaler runs only in the moving/holding states and is zero on
        // entry to RAMP_UP, so the first tick lands TICKS_PER_STEP cycles in.
        // An abort does not disturb it.
        if (active) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end else begin
            presc_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    tgt_d = tgt_clamped;
                end
            end
            S_RAMP_UP: begin
                // abort takes priority over a coinciding step.
                if (!abort_act && tick) begin
                    if (up_last) begin
                        cur_rpm_d = tgt_q;
                        hold_d    = '0;
                    end else begin
                        cur_rpm_d = cur_rpm_q + RAMP_STEP;
                    end
                end
            end
            S_HOLD: begin
                if (!abort_act && tick) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_RAMP_DOWN: begin
                if (tick) begin
                    cur_rpm_d = down_last ? 11'd0 : (cur_rpm_q - RAMP_STEP);
                end
            end
            default: begin
                cur_rpm_d = cur_rpm_q;
            end
        endcase
    end

    // Free-running PWM carrier; comparison is registered so pwm_out trails
    // the counter by one clock.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 11'd1;
        pwm_out_d = (pwm_cnt_q < cur_rpm_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tgt_q     <= '0;
            cur_rpm_q <= '0;
            presc_q   <= '0;
            hold_q    <= '0;
            pwm_cnt_q <= '0;
            pwm_out_q <= 1'b0;
        end else begin
            tgt_q     <= tgt_d;
            cur_rpm_q <= cur_rpm_d;
            presc_q   <= presc_d;
            hold_q    <= hold_d;
            pwm_cnt_q <= pwm_cnt_d;
            pwm_out_q <= pwm_out_d;
        end
    end

endmodule

// File: tb/tb_spin_motor_ramp_ctrl.sv
// Testbench for spin_motor_ramp_ctrl: directed profile scenarios plus
// randomized start/abort/target traffic compared each cycle against a
// behavioural model; a second instance with a long hold measures PWM duty.

module tb_spin_motor_ramp_ctrl;

    localparam int T     = 4;
    localparam int STEP  = 300;
    localparam int HOLDT = 2;
    localparam int MAXR  = 1400;

    logic        clk;
    logic        reset;
    logic [10:0] target_rpm;
    logic        start;
    logic        abort;
    logic [10:0] current_rpm;
    logic        pwm_out;
    logic        at_speed;
    logic        busy;
    logic        done;
    logic [2:0]  state;

    // Second instance: long hold so a full 2048-cycle PWM period can be observed at 1400.
    logic [10:0] target_p;
    logic        start_p;
    logic        abort_p;
    logic [10:0] current_rpm_p;
    logic        pwm_out_p;
    logic        at_speed_p;
    logic        busy_p;
    logic        done_p;
    logic [2:0]  state_p;

    int n_chk  = 0;
    int n_fail = 0;

    spin_motor_ramp_ctrl #(
        .TICKS_PER_STEP(T),
        .RAMP_STEP(11'(STEP)),
        .HOLD_TICKS(HOLDT),
        .MAX_RPM(11'(MAXR))
    ) u_dut (
        .clk(clk), .reset(reset), .target_rpm(target_rpm), .start(start),
        .abort(abort), .current_rpm(current_rpm), .pwm_out(pwm_out),
        .at_speed(at_speed), .busy(busy), .done(done), .state(state)
    );

    spin_motor_ramp_ctrl #(
        .TICKS_PER_STEP(T),
        .RAMP_STEP(11'(STEP)),
        .HOLD_TICKS(1000),
        .MAX_RPM(11'(MAXR))
    ) u_dut_pwm (
        .clk(clk), .reset(reset), .target_rpm(target_p), .start(start_p),
        .abort(abort_p), .current_rpm(current_rpm_p), .pwm_out(pwm_out_p),
        .at_speed(at_speed_p), .busy(busy_p), .done(done_p), .state(state_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // phase: 0 idle, 1 accelerating, 2 holding, 3 decelerating, 4 finished
    int m_phase, m_tgt, m_rpm, m_age, m_hold, m_pcnt;
    bit m_pwm;

    task automatic model_reset();
        m_phase = 0; m_tgt = 0; m_rpm = 0; m_age = 0;
        m_hold = 0; m_pcnt = 0; m_pwm = 0;
    endtask

    // Advance one clock. Ticks fall every T cycles counted from the first
    // cycle spent out of idle.
    task automatic model_step(input bit st, input bit ab, input int tin);
        bit tk;
        tk = (m_phase >= 1 && m_phase <= 3) && ((m_age % T) == T - 1);
        m_pwm  = (m_pcnt < m_rpm);
        m_pcnt = (m_pcnt + 1) % 2048;
        case (m_phase)
            0: begin
                if (st && !ab) begin
                    m_tgt   = (tin > MAXR) ? MAXR : tin;
                    m_age   = 0;
                    m_phase = (m_tgt == 0) ? 4 : 1;
                end
            end
            1: begin
                m_age++;
                if (ab) m_phase = 3;
                else if (tk) begin
                    if (m_tgt - m_rpm <= STEP) begin
                        m_rpm = m_tgt; m_phase = 2; m_hold = 0;
                    end else m_rpm = m_rpm + STEP;
                end
            end
            2: begin
                m_age++;
                if (ab) m_phase = 3;
                else if (tk) begin
                    m_hold++;
                    if (m_hold == HOLDT) m_phase = 3;
                end
            end
            3: begin
                m_age++;
                if (tk) begin
                    if (m_rpm <= STEP) begin
                        m_rpm = 0; m_phase = 4;
                    end else m_rpm = m_rpm - STEP;
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    // ---------------- per-scenario observations ----------------
    int o_max_rpm, o_done, o_hold_cyc, o_up_cyc, o_pwm_hi, o_busy;

    task automatic clear_obs();
        o_max_rpm = 0; o_done = 0; o_hold_cyc = 0; o_up_cyc = 0; o_pwm_hi = 0; o_busy = 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_step(start, abort, int'(target_rpm));
        #1;
        check("state",    int'(state),       m_phase);
        check("rpm",      int'(current_rpm), m_rpm);
        check("pwm",      int'(pwm_out),     int'(m_pwm));
        check("at_speed", int'(at_speed),    int'(m_phase == 2));
        check("busy",     int'(busy),        int'(m_phase != 0));
        check("done",     int'(done),        int'(m_phase == 4));
        if (int'(current_rpm) > o_max_rpm) o_max_rpm = int'(current_rpm);
        if (done)        o_done++;
        if (at_speed)    o_hold_cyc++;
        if (state == 3'd1) o_up_cyc++;
        if (pwm_out)     o_pwm_hi++;
        if (busy)        o_busy++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_start(input int tgt);
        target_rpm = 11'(tgt);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    int tsel [6] = '{0, 400, 800, 1200, 1400, 2000};

    initial begin
        int budget;
        model_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; target_rpm = '0;
        start_p = 1'b0; abort_p = 1'b0; target_p = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", int'(state), 0);
        check("rst_rpm",   int'(current_rpm), 0);
        check("rst_busy",  int'(busy), 0);
        check("rst_pwm",   int'(pwm_out), 0);
        #3 reset = 1'b0;

        // Basic 800 profile.
        clear_obs();
        pulse_start(800);
        run(44);
        check("p800_max",     o_max_rpm, 800);
        check("p800_done",    o_done, 1);
        check("p800_up_cyc",  o_up_cyc, 3 * T);
        check("p800_hold_cyc", o_hold_cyc, HOLDT * T);
        check("p800_busy_cyc", o_busy, 3 * T + HOLDT * T + 3 * T + 1);
        check("p800_idle", int'(busy), 0);

        // Target above the clamp.
        clear_obs();
        pulse_start(2000);
        run(60);
        check("p2000_max",  o_max_rpm, MAXR);
        check("p2000_done", o_done, 1);

        // Zero target goes straight through DONE.
        clear_obs();
        pulse_start(0);
        run(6);
        check("p0_max",  o_max_rpm, 0);
        check("p0_done", o_done, 1);
        check("p0_pwm",  o_pwm_hi, 0);
        check("p0_busy", o_busy, 1);

        // abort in HOLD on a tick edge.
        clear_obs();
        pulse_start(800);
        budget = 0;
        while (!(m_phase == 2 && (m_age % T) == T - 1) && budget < 100) begin
            step(); budget++;
        end
        check("abort_wait_timeout", int'(budget < 100), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_state", int'(state), 3);
        check("abort_rpm",   int'(current_rpm), 800);
        run(30);
        check("abort_done",  o_done, 1);

        // start and abort together in IDLE.
        start = 1'b1; abort = 1'b1; target_rpm = 11'd800;
        step();
        check("st_ab_idle", int'(state), 0);
        step();
        start = 1'b0; abort = 1'b0;
        check("st_ab_idle2", int'(busy), 0);

        // Async reset mid RAMP_UP at 600, target changed mid-ramp.
        pulse_start(1400);
        target_rpm = 11'd400;
        budget = 0;
        while (!(m_phase == 1 && m_rpm == 600) && budget < 100) begin
            step(); budget++;
        end
        check("rst_wait_timeout", int'(budget < 100), 1);
        #1 reset = 1'b1;
        #1;
        check("arst_state", int'(state), 0);
        check("arst_rpm",   int'(current_rpm), 0);
        check("arst_pwm",   int'(pwm_out), 0);
        check("arst_at",    int'(at_speed), 0);
        check("arst_busy",  int'(busy), 0);
        check("arst_done",  int'(done), 0);
        model_reset();
        #1 reset = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 3) == 0) target_rpm = 11'($urandom_range(0, 2047));
            else target_rpm = 11'(tsel[$urandom_range(0, 5)]);
            step();
        end
        start = 1'b0; abort = 1'b0;
        run(80);

        // PWM duty at 1400 on the long-hold instance.
        target_p = 11'd1400;
        start_p = 1'b1;
        step();
        start_p = 1'b0;
        budget = 0;
        while (!at_speed_p && budget < 200) begin
            step(); budget++;
        end
        check("pwm_wait_timeout", int'(budget < 200), 1);
        step();
        begin
            int hi;
            hi = 0;
            for (int i = 0; i < 2048; i++) begin
                step();
                if (pwm_out_p) hi++;
            end
            check("pwm_duty",  hi, 1400);
        end
        check("pwm_rpm_p", int'(current_rpm_p), 1400);
        check("pwm_at_p",  int'(at_speed_p), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spin_motor_ramp_ctrl.md
Name: spin_motor_ramp_ctrl

Overview:
Downstream consumer of the spin-speed selector's 11-bit selected spin speed.
On start it latches the target RPM, ramps drum speed up in fixed steps, holds at speed for a programmed time, then ramps down to 0.
It drives a PWM motor-enable derived from the current commanded RPM and reports phase and completion to the wash-cycle sequencer.

Parameters:
TICKS_PER_STEP, 1000, clk cycles per ramp/hold tick (>=2)
RAMP_STEP, 11'd100, RPM added/subtracted per tick during ramps (>=1)
HOLD_TICKS, 300, ticks spent in HOLD before ramp-down (>=1)
MAX_RPM, 11'd1400, clamp applied to latched target

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high; clock clk
target_rpm  input  11  requested spin speed (from selector: 400/800/1200/1400)
start  input  1  level; sampled only in IDLE
abort  input  1  level; forces early ramp-down
current_rpm  output  11  commanded drum speed
pwm_out  output  1  motor enable PWM
at_speed  output  1  high while in HOLD
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse on cycle completion
state  output  3  IDLE=0, RAMP_UP=1, HOLD=2, RAMP_DOWN=3, DONE=4

Behaviour:
- Reset (async, any time incl. mid-ramp): state=IDLE; current_rpm, latched target, prescaler, hold counter and PWM counter cleared to 0; pwm_out, at_speed, busy, done = 0. No ramp-down is performed on reset.
- Tick: prescaler counts 0..TICKS_PER_STEP-1 only while state is RAMP_UP, HOLD or RAMP_DOWN. Tick = single-cycle strobe when the prescaler equals TICKS_PER_STEP-1; prescaler then wraps to 0. Prescaler cleared on leaving IDLE, so the first tick occurs TICKS_PER_STEP cycles after entering RAMP_UP.
- IDLE:
  - start=1 and abort=0: latch tgt = min(target_rpm, MAX_RPM).
  - If tgt==0, go to DONE next cycle; else go to RAMP_UP.
  - start and abort both high: abort wins, stay IDLE.
- RAMP_UP, on tick:
  - If tgt - current_rpm <= RAMP_STEP: current_rpm<=tgt, go to HOLD, hold counter<=0.
  - Else current_rpm += RAMP_STEP.
  - No overflow possible: never exceeds tgt.
- HOLD:
  - Hold counter increments on each tick; after the HOLD_TICKS-th tick, go to RAMP_DOWN.
  - current_rpm is constant.
- RAMP_DOWN, on tick:
  - If current_rpm <= RAMP_STEP: current_rpm<=0, go to DONE.
  - Else current_rpm -= RAMP_STEP.
  - No underflow.
- DONE: done=1 for exactly this one cycle; next cycle IDLE unconditionally. start during DONE is ignored.
- abort=1 in RAMP_UP or HOLD: go to RAMP_DOWN next clock.
  - current_rpm is unchanged on that clock even if a tick coincides (abort has priority over the step).
  - Prescaler is not cleared.
  - abort is ignored in IDLE (except as above), RAMP_DOWN and DONE.
- target_rpm changes after latching are ignored until the next start from IDLE.
- PWM:
  - 11-bit free-running counter pwm_cnt, wraps 2047->0, runs in all states.
  - pwm_out registered: pwm_out <= (pwm_cnt < current_rpm). One-cycle latency.
  - current_rpm=0 gives pwm_out constantly 0.
- Outputs at_speed, busy and state are decoded from the registered state. All outputs are registered or decoded purely from registers, with no combinational input-to-output path.

Test Plan:
- Params TICKS_PER_STEP=4, RAMP_STEP=300, HOLD_TICKS=2; target_rpm=800, one-cycle start pulse.
  - Required: current_rpm steps 0->300->600->800 on successive ticks (4 cycles apart), then HOLD with at_speed=1 for 2 ticks.
  - Then 800->500->200->0, DONE with done high for 1 cycle, then IDLE with busy=0.
- target_rpm=2000 (above MAX_RPM=1400) -> ramp terminates at exactly 1400; never exceeds it.
- target_rpm=0 with start -> IDLE->DONE->IDLE, done pulses once, current_rpm stays 0, pwm_out stays 0.
- abort in HOLD at 800 coinciding with a tick -> RAMP_DOWN next cycle with current_rpm still 800; then 500, 200, 0, DONE. start+abort together in IDLE -> stays IDLE.
- Async reset asserted mid-RAMP_UP at current_rpm=600 -> all outputs 0 immediately (before the next clk edge), state=IDLE. A change of target_rpm mid-ramp has no effect.
- PWM check with current_rpm=1400 held -> pwm_out high for 1400 of every 2048 cycles, delayed one cycle relative to pwm_cnt.
